// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle ALU source / datapath control FSM.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13,
    S_ABORT    = 4'd14
  } state_e;

  // ALU source-B select; 3..5 are reserved and never produced here
  localparam logic [2:0] SRCB_REG  = 3'd0;
  localparam logic [2:0] SRCB_FOUR = 3'd1;
  localparam logic [2:0] SRCB_IMM  = 3'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // States that hold mem_req and run the watchdog
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct field to ALU operation decoder.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  // Unknown funct falls back to ADD with valid low; the FSM traps it
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_src_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// ALU operand selects, datapath enables and a memory-wait watchdog.
module alu_src_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255  // must be >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] state_dbg
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting, expire;
  logic [2:0]       r_op;
  logic             r_valid;

  alu_op_decode u_dec (
    .funct  (funct),
    .alu_op (r_op),
    .valid  (r_valid)
  );

  // The cycle that would bring the counter to MEM_TIMEOUT aborts, unless ready
  assign waiting = is_wait_state(state_q);
  assign expire  = waiting && !mem_ready && (cnt_q >= CNT_LAST);

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)   state_d = S_DECODE;
        else if (expire) state_d = S_ABORT;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:    state_d = S_EXEC_R;
          OP_ADDI:     state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:      state_d = S_BRANCH;
          OP_J:        state_d = S_JUMP;
          default:     state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   state_d = r_valid ? S_WB_R : S_ILLEGAL;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)   state_d = S_WB_MEM;
        else if (expire) state_d = S_ABORT;
      end
      S_MEM_WR: begin
        if (mem_ready)   state_d = S_FETCH;
        else if (expire) state_d = S_ABORT;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_ILLEGAL, S_ABORT:
        state_d = S_FETCH;
      default: state_d = S_RST;
    endcase
  end

  // Wait counter: cleared on entering a wait state or on ready, saturates
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && is_wait_state(state_d))
      cnt_d = '0;
    else if (waiting) begin
      if (mem_ready)
        cnt_d = '0;
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output decode: Moore from state, Mealy ir_write/pc_write in FETCH and BRANCH
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMM;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_op;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_WB_I:   reg_write = 1'b1;
      S_MEM_RD: mem_req   = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = alu_zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      S_ILLEGAL: illegal = 1'b1;
      S_ABORT:   timeout = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule
